// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
//   stage_ctl_t  : per-beat control carried alongside each stage register
//   slice_width  : bits handled by one carry-chain slice
//   max_pos/neg  : signed saturation limits for a given result width
// No ports; imported by addsub_slice and pipelined_addsub.
package alu_pkg;

  // Upper bound on WIDTH so the saturation helpers can return a fixed-size value.
  localparam int MAX_WIDTH = 128;

  // Operand/partial-sum vectors are WIDTH-dependent and live next to this
  // struct in each stage register; this carries everything else of the beat.
  typedef struct packed {
    logic valid;  // stage holds a real beat (not a bubble)
    logic sub;    // beat is A-B
    logic sat;    // clamp on signed overflow
    logic carry;  // carry into the next slice (out of the MSB slice at the end)
  } stage_ctl_t;

  function automatic int slice_width(int width, int stages);
    return width / stages;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] max_pos(int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] max_neg(int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle of the pipelined add/subtract unit.
//   in_valid/in_ready   : operand beat handshake (a, b, sub, sat)
//   out_valid/out_ready : result beat handshake (result + flags)
// master = producer/consumer side, slave = the arithmetic unit.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             p_overflow;
  logic             n_overflow;
  logic             carry_out;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, result, p_overflow, n_overflow, carry_out, zero
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, result, p_overflow, n_overflow, carry_out, zero
  );
endinterface

// File: rtl/addsub_slice.sv
// One carry-chain slice plus its stage register.
// Adds bits [IDX*SW +: SW] of a_in and bx_in (B already conditionally
// inverted) with ctl_in.carry, drops the slice sum into the partial-sum
// vector and registers everything when en is high; holds otherwise.
//   clk, reset        : clock, synchronous active-high reset
//   en                : pipeline advance
//   a_in/bx_in/s_in   : operands and partial sum from the previous stage
//   ctl_in            : beat control from the previous stage
//   a_out/.../ctl_out : registered stage payload
module addsub_slice
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] bx_in,
  input  logic [WIDTH-1:0] s_in,
  input  stage_ctl_t       ctl_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] bx_out,
  output logic [WIDTH-1:0] s_out,
  output stage_ctl_t       ctl_out
);

  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int LO = IDX * SW;

  logic [SW:0]      slice_sum;
  logic [WIDTH-1:0] s_next;
  stage_ctl_t       ctl_next;

  always_comb begin
    slice_sum = {1'b0, a_in[LO +: SW]} + {1'b0, bx_in[LO +: SW]} + {{SW{1'b0}}, ctl_in.carry};
    s_next              = s_in;
    s_next[LO +: SW]    = slice_sum[SW-1:0];
    ctl_next            = ctl_in;
    ctl_next.carry      = slice_sum[SW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out   <= '0;
      bx_out  <= '0;
      s_out   <= '0;
      ctl_out <= '0;
    end else if (en) begin
      a_out   <= a_in;
      bx_out  <= bx_in;
      s_out   <= s_next;
      ctl_out <= ctl_next;
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined signed/unsigned add/subtract with overflow flags and optional
// signed saturation. The carry chain is split into STAGES slices, one per
// register stage; the last stage register is the output register.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of pipelined_addsub_if (operands in, result out)
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  pipelined_addsub_if.slave bus
);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 ||
      WIDTH > MAX_WIDTH) begin : g_param_check
    $error("pipelined_addsub: illegal WIDTH/STAGES combination");
  end

  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(max_neg(WIDTH));

  // Index 0 is the unregistered input beat; index k+1 is the output of stage k.
  logic [STAGES:0][WIDTH-1:0] a_st;
  logic [STAGES:0][WIDTH-1:0] bx_st;
  logic [STAGES:0][WIDTH-1:0] s_st;
  stage_ctl_t [STAGES:0]      ctl_st;

  logic             advance;
  logic             sign_a;
  logic             sign_b;
  logic             sign_s;
  logic             p_ovf;
  logic             n_ovf;
  logic [WIDTH-1:0] result_c;

  // Global stall: every stage moves only when the output slot is free or
  // being drained, so bubbles stay where they are.
  assign advance      = !ctl_st[STAGES].valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction is A + ~B + 1; the +1 enters as the carry into slice 0.
  assign a_st[0]  = bus.a;
  assign bx_st[0] = bus.sub ? ~bus.b : bus.b;
  assign s_st[0]  = '0;
  assign ctl_st[0] = '{valid: bus.in_valid, sub: bus.sub, sat: bus.sat, carry: bus.sub};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_slice #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .en      (advance),
      .a_in    (a_st[k]),
      .bx_in   (bx_st[k]),
      .s_in    (s_st[k]),
      .ctl_in  (ctl_st[k]),
      .a_out   (a_st[k+1]),
      .bx_out  (bx_st[k+1]),
      .s_out   (s_st[k+1]),
      .ctl_out (ctl_st[k+1])
    );
  end

  assign sign_a = a_st[STAGES][WIDTH-1];
  assign sign_b = bx_st[STAGES][WIDTH-1];
  assign sign_s = s_st[STAGES][WIDTH-1];

  // Flags describe the raw arithmetic, before any clamping.
  assign p_ovf = !sign_a && !sign_b && sign_s;
  assign n_ovf = sign_a && sign_b && !sign_s;

  always_comb begin
    result_c = s_st[STAGES];
    if (ctl_st[STAGES].sat && p_ovf) begin
      result_c = SAT_POS;
    end else if (ctl_st[STAGES].sat && n_ovf) begin
      result_c = SAT_NEG;
    end
  end

  assign bus.out_valid  = ctl_st[STAGES].valid;
  assign bus.result     = result_c;
  assign bus.p_overflow = p_ovf;
  assign bus.n_overflow = n_ovf;
  assign bus.carry_out  = ctl_st[STAGES].carry;
  // Gated with valid so an empty (reset) output register does not report zero.
  assign bus.zero       = ctl_st[STAGES].valid && (result_c == '0);

  // Below the sign bits the operands and the mode bit are no longer needed
  // once the final slice has been added.
  logic unused_final_bits;
  assign unused_final_bits = ^{a_st[STAGES][WIDTH-2:0], bx_st[STAGES][WIDTH-2:0],
                               ctl_st[STAGES].sub};

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W  = 32;
  localparam int ST = 2;

  typedef struct {
    longint res;
    bit     p;
    bit     n;
    bit     c;
    bit     z;
    int     left;  // advancing cycles still needed before the beat shows at the output
  } exp_t;

  logic clk;
  logic reset;
  logic rst8 = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  bit accepted;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) abus ();

  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (abus)
  );

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: true signed/unsigned arithmetic on integers, no bit slicing.
  function automatic exp_t model(int w, longint a, longint b, bit sub, bit sat);
    longint half, full, sa, sb, r;
    exp_t e;
    half = longint'(1) << (w - 1);
    full = half * 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    r  = sub ? sa - sb : sa + sb;
    e.p = (r > half - 1);
    e.n = (r < -half);
    e.c = sub ? (a >= b) : ((a + b) >= full);
    if (sat && e.p)      e.res = half - 1;
    else if (sat && e.n) e.res = half;
    else                 e.res = r & (full - 1);
    e.z = (e.res == 0);
    e.left = 0;
    return e;
  endfunction

  function automatic longint pick();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return 'h7FFF_FFFF;
      3:       return 'h8000_0000;
      4:       return 'hFFFF_FFFF;
      default: return {32'd0, $urandom};
    endcase
  endfunction

  // Called at a negedge with inputs already set; checks the cycle and
  // updates the scoreboard for the coming posedge.
  task automatic tick();
    bit   vis, adv, acc;
    exp_t e;
    #1;
    vis = (q.size() > 0) && (q[0].left == 0);
    adv = !vis || abus.out_ready;
    check_eq("in_ready", abus.in_ready, adv);
    check_eq("out_valid", abus.out_valid, vis);
    if (vis) begin
      check_eq("result", abus.result, q[0].res);
      check_eq("p_ovf", abus.p_overflow, q[0].p);
      check_eq("n_ovf", abus.n_overflow, q[0].n);
      check_eq("carry", abus.carry_out, q[0].c);
      check_eq("zero", abus.zero, q[0].z);
    end
    acc = abus.in_valid && adv && !reset;
    accepted = acc;
    if (reset) begin
      q.delete();
    end else begin
      if (vis && abus.out_ready) void'(q.pop_front());
      if (adv) begin
        for (int i = 0; i < q.size(); i++)
          if (q[i].left > 0) q[i].left = q[i].left - 1;
      end
      if (acc) begin
        e = model(W, {32'd0, abus.a}, {32'd0, abus.b}, abus.sub, abus.sat);
        e.left = ST - 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic send(longint a, longint b, bit s, bit t);
    abus.in_valid = 1'b1;
    abus.a   = 32'(a);
    abus.b   = 32'(b);
    abus.sub = s;
    abus.sat = t;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) tick();
    check_eq("send_accept", accepted, 1);
    abus.in_valid = 1'b0;
  endtask

  task automatic load_beat(int n);
    abus.a   = 32'(100 + n * 7);
    abus.b   = 32'(n * 3);
    abus.sub = n[0];
    abus.sat = 1'b0;
  endtask

  // WIDTH=8 sweep: latency equals STAGES, overflow and saturation at 8 bits.
  for (genvar g = 0; g < 3; g++) begin : g_w8
    localparam int ST8 = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    pipelined_addsub_if #(.WIDTH(8)) bus8 ();
    bit done;

    pipelined_addsub #(.WIDTH(8), .STAGES(ST8)) u_dut8 (
      .clk   (clk),
      .reset (rst8),
      .bus   (bus8)
    );

    initial begin : run
      int     lat;
      exp_t   e;
      longint va, vb;
      bit     vs, vt;
      bus8.in_valid  = 1'b0;
      bus8.a         = '0;
      bus8.b         = '0;
      bus8.sub       = 1'b0;
      bus8.sat       = 1'b0;
      bus8.out_ready = 1'b1;
      wait (rst8 == 1'b0);
      #1;
      check_eq("w8_rst_valid", bus8.out_valid, 0);
      check_eq("w8_rst_result", bus8.result, 0);
      check_eq("w8_rst_ready", bus8.in_ready, 1);
      for (int v = 0; v < 3; v++) begin
        va = (v == 2) ? 'h80 : 'h7F;
        vb = 1;
        vs = (v == 2);
        vt = (v != 0);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.a   = 8'(va);
        bus8.b   = 8'(vb);
        bus8.sub = vs;
        bus8.sat = vt;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        e = model(8, va, vb, vs, vt);
        check_eq("w8_latency", lat, ST8);
        check_eq("w8_result", bus8.result, e.res);
        check_eq("w8_p_ovf", bus8.p_overflow, e.p);
        check_eq("w8_n_ovf", bus8.n_overflow, e.n);
        check_eq("w8_carry", bus8.carry_out, e.c);
        @(negedge clk);
        check_eq("w8_consumed", bus8.out_valid, 0);
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    reset          = 1'b1;
    abus.in_valid  = 1'b0;
    abus.a         = '0;
    abus.b         = '0;
    abus.sub       = 1'b0;
    abus.sat       = 1'b0;
    abus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", abus.out_valid, 0);
    check_eq("rst_result", abus.result, 0);
    check_eq("rst_p_ovf", abus.p_overflow, 0);
    check_eq("rst_n_ovf", abus.n_overflow, 0);
    check_eq("rst_carry", abus.carry_out, 0);
    check_eq("rst_zero", abus.zero, 0);
    @(negedge clk);
    reset = 1'b0;
    rst8  = 1'b0;

    // Back-to-back adds, no saturation.
    send('h8000_0001, 'h8000_0001, 0, 0);
    send('h7DDD_DDDD, 'h7DDD_DDDD, 0, 0);
    send(5, 7, 0, 0);
    send('hFFFF_FFFB, 'hFFFF_FFF9, 0, 0);
    send(8, 'hFFFF_FFF7, 0, 0);
    // Same overflowing adds with saturation.
    send('h8000_0001, 'h8000_0001, 0, 1);
    send('h7DDD_DDDD, 'h7DDD_DDDD, 0, 1);
    // Subtractions, mixed modes back-to-back.
    send(3, 5, 1, 0);
    send(5, 5, 1, 0);
    send('h8000_0000, 1, 1, 0);
    send('h8000_0000, 1, 1, 1);
    send('h7FFF_FFFF, 'hFFFF_FFFF, 1, 1);
    repeat (4) tick();

    // Backpressure: four beats, consumer stalls for three cycles mid-stream.
    n = 0;
    load_beat(n);
    abus.in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      abus.out_ready = (c < 3 || c > 5);
      tick();
      if (accepted) begin
        n++;
        if (n < 4) load_beat(n);
        else abus.in_valid = 1'b0;
      end
    end
    check_eq("bp_all_sent", n, 4);
    check_eq("bp_drained", q.size(), 0);

    // Reset with two beats in flight: nothing may come out afterwards.
    abus.out_ready = 1'b1;
    send(11, 22, 0, 0);
    send(33, 44, 1, 0);
    abus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    abus.out_ready = 1'b1;
    repeat (6) tick();

    // Random operands, modes, valid gaps and backpressure.
    for (int c = 0; c < 400; c++) begin
      if (!abus.in_valid || accepted) begin
        abus.in_valid = ($urandom_range(0, 3) != 0);
        abus.a   = 32'(pick());
        abus.b   = 32'(pick());
        abus.sub = 1'($urandom_range(0, 1));
        abus.sat = 1'($urandom_range(0, 1));
      end
      abus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    abus.in_valid  = 1'b0;
    abus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check_eq("final_drain", q.size(), 0);

    for (int i = 0; i < 200 && !(g_w8[0].done && g_w8[1].done && g_w8[2].done); i++)
      @(negedge clk);
    check_eq("w8_done", {g_w8[2].done, g_w8[1].done, g_w8[0].done}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
